// File: rtl/sign_extention_pkg.sv
// sign_extention_pkg: extension mode encodings and default widths shared by the sign-extension slice.
package sign_extention_pkg;
    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 32;
    typedef enum logic [2:0] {
        SEXT  = 3'd0,
        ZEXT  = 3'd1,
        SEXT8 = 3'd2,
        ZEXT8 = 3'd3,
        UPPER = 3'd4
    } ext_mode_e;
endpackage

// File: rtl/sign_extention_core.sv
// sign_ext_core: combinational immediate extension for all modes; reserved modes give zero plus err.
module sign_ext_core
    import sign_extention_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [IN_W-1:0]  in,
    input  logic [2:0]       mode,
    output logic [OUT_W-1:0] result,
    output logic             err
);
    always_comb begin
        err    = mode > UPPER;
        result = mode == SEXT  ? {{(OUT_W-IN_W){in[IN_W-1]}}, in} :
                 mode == ZEXT  ? {{(OUT_W-IN_W){1'b0}}, in} :
                 mode == SEXT8 ? {{(OUT_W-8){in[7]}}, in[7:0]} :
                 mode == ZEXT8 ? {{(OUT_W-8){1'b0}}, in[7:0]} :
                 mode == UPPER ? {in, {(OUT_W-IN_W){1'b0}}} :
                                 '0;
    end
endmodule

// File: rtl/sign_extention.sv
// sign_extention: combinational SEXT output plus a one-entry valid/ready register of the selected mode.
module sign_extention
    import sign_extention_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic [2:0]       mode,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             out_valid,
    output logic             in_ready,
    output logic             mode_err
);
    if (!(OUT_W > IN_W && IN_W >= 8)) begin : g_bad_widths
        $error("sign_extention: need OUT_W > IN_W >= 8");
    end

    logic [OUT_W-1:0] result;
    logic             err;
    logic             accept;

    sign_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .in(in),
        .mode(mode),
        .result(result),
        .err(err)
    );

    assign out      = {{(OUT_W-IN_W){in[IN_W-1]}}, in};
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Accept takes priority over drain so consume+accept in one cycle leaves no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
            mode_err  <= 1'b0;
        end else if (accept) begin
            out_q     <= result;
            out_valid <= 1'b1;
            mode_err  <= err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sign_extention.sv
// tb_sign_extention: directed and randomized checks of sign_extention against an arithmetic reference model.
module tb_sign_extention;
    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = '0;
    logic [2:0]  mode = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] out, out_q;
    logic        out_valid, in_ready, mode_err;
    int          tests = 0;
    int          fails = 0;

    sign_extention dut (
        .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .in_valid(in_valid),
        .out_ready(out_ready), .out(out), .out_q(out_q), .out_valid(out_valid),
        .in_ready(in_ready), .mode_err(mode_err)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [31:0] ref_ext(input logic [15:0] x, input logic [2:0] m);
        logic [7:0] lo;
        lo = x[7:0];
        case (m)
            3'd0:    return int'($signed(x));
            3'd1:    return 32'(x);
            3'd2:    return int'($signed(lo));
            3'd3:    return 32'(x) & 32'hFF;
            3'd4:    return 32'(x) << 16;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] v33 [5];
        logic [31:0] e33 [5];
        logic [31:0] e34 [5];
        logic        m_valid, m_err, exp_rdy, acc;
        logic [31:0] m_q;
        v33 = '{16'd0, 16'd15, 16'd127, 16'd32768, 16'd65535};
        e33 = '{32'h0, 32'hF, 32'h7F, 32'hFFFF8000, 32'hFFFFFFFF};
        e34 = '{32'hFFFF8080, 32'h00008080, 32'hFFFFFF80, 32'h00000080, 32'h80800000};
        #1;
        check("rst_out_q", out_q, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_mode_err", 32'(mode_err), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            in = v33[i];
            #100;
            check("comb_out", out, e33[i]);
        end
        rst_n = 1'b1;
        #3;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        clk_en = 1'b1;
        step();
        step();
        for (int m = 0; m < 5; m++) begin
            in = 16'h8080; mode = 3'(m); in_valid = 1'b1; out_ready = 1'b1;
            step();
            check("mode_out_q", out_q, e34[m]);
            check("mode_out_valid", 32'(out_valid), 32'h1);
            check("mode_err_clear", 32'(mode_err), 32'h0);
            in_valid = 1'b0;
            step();
            check("drain_out_valid", 32'(out_valid), 32'h0);
        end
        in = 16'h7FFF; mode = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in = 16'($urandom); mode = 3'($urandom);
            #1;
            check("stall_out_q", out_q, 32'h00007FFF);
            check("stall_out_valid", 32'(out_valid), 32'h1);
            check("stall_in_ready", 32'(in_ready), 32'h0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'h1);
        step();
        check("release_out_valid", 32'(out_valid), 32'h0);
        check("release_out_q_kept", out_q, 32'h00007FFF);
        mode = 3'd0; in_valid = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            in = 16'(v);
            step();
            check("b2b_out_q", out_q, 32'(v));
            check("b2b_out_valid", 32'(out_valid), 32'h1);
        end
        in = 16'h1234; mode = 3'd6;
        step();
        check("rsv_out_q", out_q, 32'h0);
        check("rsv_mode_err", 32'(mode_err), 32'h1);
        in = 16'h0005; mode = 3'd0;
        step();
        check("after_rsv_mode_err", 32'(mode_err), 32'h0);
        check("after_rsv_out_q", out_q, 32'h5);
        in_valid = 1'b0;
        step();
        m_valid = 1'b0; m_q = 32'h5; m_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in = 16'($urandom); mode = 3'($urandom_range(0, 7));
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            #1;
            exp_rdy = !m_valid || out_ready;
            acc = in_valid && exp_rdy;
            check("rnd_out", out, int'($signed(in)));
            check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            if (acc) begin
                m_q = ref_ext(in, mode); m_err = mode > 3'd4; m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            step();
            check("rnd_out_q", out_q, m_q);
            check("rnd_out_valid", 32'(out_valid), 32'(m_valid));
            check("rnd_mode_err", 32'(mode_err), 32'(m_err));
        end
        in = 16'h9ABC; mode = 3'd1; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_q", out_q, 32'h0);
        check("async_rst_out_valid", 32'(out_valid), 32'h0);
        check("async_rst_mode_err", 32'(mode_err), 32'h0);
        check("async_rst_in_ready", 32'(in_ready), 32'h1);
        check("async_rst_out", out, 32'hFFFF9ABC);
        @(negedge clk);
        rst_n = 1'b1;
        in = 16'h0042; mode = 3'd1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        check("post_rst_out_q", out_q, 32'h42);
        check("post_rst_out_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sign_extention.md
SIGN_EXTENTION -- requirements
Module: sign_extention

Interface
REQ-001 Parameter IN_W, default 16, immediate input width in bits.
REQ-002 Parameter OUT_W, default 32, extended output width in bits; SHALL satisfy OUT_W > IN_W >= 8.
REQ-003 clk  input  1  single clock; all registers on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in  input  IN_W  immediate to extend.
REQ-006 mode  input  3  extension mode: 0 SEXT, 1 ZEXT, 2 SEXT8, 3 ZEXT8, 4 UPPER; 5-7 reserved.
REQ-007 in_valid  input  1  qualifies in/mode for the registered path.
REQ-008 out_ready  input  1  downstream accepts out_q this cycle.
REQ-009 out  output  OUT_W  combinational sign extension of in, always SEXT regardless of mode.
REQ-010 out_q  output  OUT_W  registered result of selected mode.
REQ-011 out_valid  output  1  out_q holds an unconsumed result.
REQ-012 in_ready  output  1  stage can accept a new input this cycle.
REQ-013 mode_err  output  1  registered flag: accepted transfer used a reserved mode.

Function
REQ-014 out SHALL equal {(OUT_W-IN_W) copies of in[IN_W-1], in}, zero latency, independent of clk/rst_n.
REQ-015 SEXT: replicate in[IN_W-1] into upper OUT_W-IN_W bits.
REQ-016 ZEXT: upper OUT_W-IN_W bits zero, lower bits = in.
REQ-017 SEXT8: replicate in[7] into bits OUT_W-1..8; bits 7..0 = in[7:0]; in[IN_W-1:8] ignored.
REQ-018 ZEXT8: bits OUT_W-1..8 zero; bits 7..0 = in[7:0].
REQ-019 UPPER: in placed at bits OUT_W-1..OUT_W-IN_W, remaining low bits zero.
REQ-020 Reserved mode: result zero and mode_err = 1 with the transfer; mode_err = 0 for valid modes.
REQ-021 in_ready = !out_valid || out_ready (one-entry skid-free pipeline register).
REQ-022 Transfer accepted when in_valid && in_ready; result appears on out_q with out_valid = 1 the next cycle (latency 1).
REQ-023 out_q, out_valid and mode_err SHALL hold stable while out_valid && !out_ready.
REQ-024 out_valid clears when out_ready is high and no new transfer is accepted that cycle.
REQ-025 Simultaneous consume and accept: out_q replaced by the new result, out_valid stays 1, no bubble.
REQ-026 Inputs are don't-care when in_valid = 0; registered outputs do not change.

Reset
REQ-027 rst_n low SHALL immediately force out_q = 0, out_valid = 0, mode_err = 0, regardless of clk.
REQ-028 in_ready SHALL read 1 during and after reset.
REQ-029 Reset mid-transfer discards the held result; first accept after rst_n rises behaves as in REQ-022.
REQ-030 out is unaffected by reset.

Structure
REQ-031 Mode encodings (SEXT, ZEXT, SEXT8, ZEXT8, UPPER) and default widths SHALL live in a shared package.
REQ-032 One combinational sub-module, sign_ext_core (in, mode -> result, err), SHALL compute REQ-015..REQ-020; the top instantiates it and adds the pipeline register.

Verification
REQ-033 in = 0, 15, 127, 32768, 65535 (held 100 ns each, no clock) -> out = 0x00000000, 0x0000000F, 0x0000007F, 0xFFFF8000, 0xFFFFFFFF.
REQ-034 mode SEXT/ZEXT/SEXT8/ZEXT8/UPPER with in = 0x8080, in_valid=1, out_ready=1 -> out_q next cycle = 0xFFFF8080, 0x00008080, 0xFFFFFF80, 0x00000080, 0x80800000.
REQ-035 Accept in = 0x7FFF, hold out_ready = 0 for 5 cycles -> out_q = 0x00007FFF stable, out_valid = 1, in_ready = 0; release -> consumed in one cycle.
REQ-036 Back-to-back in = 1, 2, 3 with out_ready = 1 every cycle -> out_q 1, 2, 3 on consecutive cycles, out_valid continuously 1.
REQ-037 mode = 6, in = 0x1234 -> out_q = 0, mode_err = 1; next transfer with mode 0 -> mode_err = 0.
REQ-038 Assert rst_n = 0 between clock edges while out_valid = 1 -> out_q = 0, out_valid = 0 immediately; out still equals SEXT(in).
